// File: rtl/mem_share_arbiter_if.sv
// Bundle of the two requester ports plus the shared read-return and status
// signals of mem_share_arbiter.
interface mem_share_arbiter_if #(
  parameter int DW = 8,
  parameter int AW = 4
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic [DW-1:0] rdata;
  logic          rmatch;
  logic          busy;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, rmatch, busy
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, rmatch, busy
  );
endinterface

// File: rtl/mem_share_arbiter.sv
// Round-robin two-requester controller for a 16 x 8 register array with a
// clearing pass after reset. Define MEM_ARB_MATCH_EN to build the rmatch compare.
module mem_share_arbiter #(
  parameter int DW    = 8,
  parameter int AW    = 4,
  parameter int DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  mem_share_arbiter_if.slave  bus
);
  typedef enum logic {INIT, RUN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] clr_ptr_q, clr_ptr_d;
  logic          last_gnt_q, last_gnt_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic [DW-1:0] mem [DEPTH];

  logic          gnt0, gnt1;
  logic          acc_we;
  logic [AW-1:0] acc_addr;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          rd_en;
  logic [DW-1:0] rd_word;

  assign rd_word = mem[acc_addr];

  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    last_gnt_d = last_gnt_q;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    acc_we     = 1'b0;
    acc_addr   = '0;
    mem_we     = 1'b0;
    mem_addr   = clr_ptr_q;
    mem_wdata  = '0;
    rd_en      = 1'b0;
    case (state_q)
      INIT: begin
        mem_we    = 1'b1;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == AW'(DEPTH - 1)) state_d = RUN;
      end
      RUN: begin
        // last_gnt_q = 1 means requester 1 won most recently, so 0 wins a tie
        gnt0 = bus.req0 && (!bus.req1 || last_gnt_q);
        gnt1 = bus.req1 && !gnt0;
        if (gnt0) begin
          acc_we     = bus.we0;
          acc_addr   = bus.addr0;
          mem_wdata  = bus.wdata0;
          last_gnt_d = 1'b0;
        end else if (gnt1) begin
          acc_we     = bus.we1;
          acc_addr   = bus.addr1;
          mem_wdata  = bus.wdata1;
          last_gnt_d = 1'b1;
        end
        mem_addr = acc_addr;
        mem_we   = (gnt0 || gnt1) && acc_we;
        rd_en    = (gnt0 || gnt1) && !acc_we;
      end
      default: state_d = INIT;
    endcase
    rvalid0_d = rd_en && gnt0;
    rvalid1_d = rd_en && gnt1;
    rdata_d   = rd_en ? rd_word : rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INIT;
      clr_ptr_q  <= '0;
      last_gnt_q <= 1'b1;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      last_gnt_q <= last_gnt_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      rdata_q    <= rdata_d;
    end
  end

  // Storage carries no reset; its contents come only from the clearing pass.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

`ifdef MEM_ARB_MATCH_EN
  logic rmatch_q, rmatch_d;

  always_comb begin
    rmatch_d = rmatch_q;
    if (rd_en) rmatch_d = (rd_word == DW'(0)) || (rd_word == DW'(5)) || (rd_word == DW'(10));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rmatch_q <= 1'b0;
    else     rmatch_q <= rmatch_d;
  end

  assign bus.rmatch = rmatch_q;
`else
  assign bus.rmatch = 1'b0;
`endif

  assign bus.gnt0    = gnt0;
  assign bus.gnt1    = gnt1;
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;
  assign bus.rdata   = rdata_q;
  assign bus.busy    = (state_q == INIT);
endmodule

// File: tb/tb_mem_share_arbiter.sv
// Directed bench for mem_share_arbiter: clearing pass, arbitration, read
// latency, reset behaviour and the optional rmatch compare.
module tb_mem_share_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mem_share_arbiter_if bus ();
  mem_share_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1);
  end

  task automatic clear_reqs();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.we0  = 1'b0; bus.we1  = 1'b0;
    bus.addr0 = '0;  bus.addr1 = '0;
    bus.wdata0 = '0; bus.wdata1 = '0;
  endtask

  // Present one request at the falling edge and let combinational grant settle.
  task automatic drive(input bit who, input bit we, input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    clear_reqs();
    if (!who) begin
      bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end
    #1;
    $display("[TB] req%0d %s addr=%0d wdata=%h gnt0=%b gnt1=%b", who, we ? "wr" : "rd", a, d, bus.gnt0, bus.gnt1);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    clear_reqs();
    #1;
  endtask

  task automatic wait_init(output int cycles);
    cycles = 0;
    while (bus.busy === 1'b1 && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_reqs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int cyc;
    clear_reqs();
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_ctrl: got %b required 0000", {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1});
    end
    n_tests++;
    if (bus.rdata !== 8'h00) begin n_fail++; $display("FAIL rst_rdata: got %h required 00", bus.rdata); end
    n_tests++;
    if (bus.rmatch !== 1'b0) begin n_fail++; $display("FAIL rst_rmatch: got %b required 0", bus.rmatch); end
    n_tests++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy: got %b required 1", bus.busy); end
    // Both requesters ask throughout the clearing pass; no grant may appear.
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    rst = 1'b0;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.busy === 1'b1) begin
        n_tests++;
        if ({bus.gnt0, bus.gnt1} !== 2'b00) begin
          n_fail++; $display("FAIL init_gnt: cycle %0d got %b required 00", cyc, {bus.gnt0, bus.gnt1});
        end
      end
    end
    clear_reqs();
    n_tests++;
    if (cyc !== 16) begin n_fail++; $display("FAIL init_len: got %0d required 16", cyc); end
    $display("[TB] init pass took %0d cycles", cyc);
  endtask

  task automatic test_init_reads();
    for (int a = 0; a < 16; a++) begin
      drive(a[0], 1'b0, 4'(a), 8'h00);
      n_tests++;
      if ({bus.gnt0, bus.gnt1} !== (a[0] ? 2'b01 : 2'b10)) begin
        n_fail++; $display("FAIL init_rd_gnt: addr %0d got %b required %b", a, {bus.gnt0, bus.gnt1}, a[0] ? 2'b01 : 2'b10);
      end
      idle_cycle();
      n_tests++;
      if ({bus.rvalid0, bus.rvalid1, bus.rdata} !== {~a[0], a[0], 8'h00}) begin
        n_fail++; $display("FAIL init_rd: addr %0d got rv=%b%b rdata=%h required rv=%b%b rdata=00",
                           a, bus.rvalid0, bus.rvalid1, bus.rdata, ~a[0], a[0]);
      end
    end
  endtask

  task automatic test_write_read();
    drive(1'b0, 1'b1, 4'd3, 8'hA5);
    n_tests++;
    if (bus.gnt0 !== 1'b1) begin n_fail++; $display("FAIL wr_gnt0: got %b required 1", bus.gnt0); end
    drive(1'b0, 1'b0, 4'd3, 8'h00);
    n_tests++;
    if (bus.rvalid0 !== 1'b0) begin n_fail++; $display("FAIL wr_rvalid0: got %b required 0", bus.rvalid0); end
    n_tests++;
    if (bus.gnt0 !== 1'b1) begin n_fail++; $display("FAIL rd_gnt0: got %b required 1", bus.gnt0); end
    idle_cycle();
    n_tests++;
    if ({bus.rvalid0, bus.rvalid1, bus.rdata} !== {2'b10, 8'hA5}) begin
      n_fail++; $display("FAIL wr_rd: got rv=%b%b rdata=%h required rv=10 rdata=a5", bus.rvalid0, bus.rvalid1, bus.rdata);
    end
    idle_cycle();
    n_tests++;
    if ({bus.rvalid0, bus.rvalid1, bus.rdata} !== {2'b00, 8'hA5}) begin
      n_fail++; $display("FAIL wr_rd_hold: got rv=%b%b rdata=%h required rv=00 rdata=a5", bus.rvalid0, bus.rvalid1, bus.rdata);
    end
  endtask

  task automatic test_contention();
    int  cyc;
    bit  odd;
    do_reset();
    wait_init(cyc);
    n_tests++;
    if (cyc !== 16) begin n_fail++; $display("FAIL cont_init: got %0d required 16", cyc); end
    @(negedge clk);
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 4'd1; bus.wdata0 = 8'h11;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 4'd2; bus.wdata1 = 8'h22;
    #1;
    n_tests++;
    if ({bus.gnt0, bus.gnt1} !== 2'b10) begin n_fail++; $display("FAIL first_tie: got %b required 10", {bus.gnt0, bus.gnt1}); end
    @(negedge clk);
    bus.req0 = 1'b0;
    #1;
    n_tests++;
    if ({bus.gnt0, bus.gnt1} !== 2'b01) begin n_fail++; $display("FAIL solo_gnt1: got %b required 01", {bus.gnt0, bus.gnt1}); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 4'd1;
      bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 4'd2;
      #1;
      odd = (i % 2 == 1);
      $display("[TB] contention cycle %0d gnt=%b%b rv=%b%b rdata=%h", i, bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.rdata);
      n_tests++;
      if ({bus.gnt0, bus.gnt1} !== {~odd, odd}) begin
        n_fail++; $display("FAIL cont_gnt: cycle %0d got %b required %b", i, {bus.gnt0, bus.gnt1}, {~odd, odd});
      end
      if (i > 0) begin
        n_tests++;
        if ({bus.rvalid0, bus.rvalid1, bus.rdata} !== {odd, ~odd, odd ? 8'h11 : 8'h22}) begin
          n_fail++; $display("FAIL cont_rv: cycle %0d got rv=%b%b rdata=%h required rv=%b%b rdata=%h",
                             i, bus.rvalid0, bus.rvalid1, bus.rdata, odd, ~odd, odd ? 8'h11 : 8'h22);
        end
      end
    end
    idle_cycle();
    n_tests++;
    if ({bus.rvalid0, bus.rvalid1, bus.rdata} !== {2'b01, 8'h22}) begin
      n_fail++; $display("FAIL cont_last: got rv=%b%b rdata=%h required rv=01 rdata=22", bus.rvalid0, bus.rvalid1, bus.rdata);
    end
  endtask

  task automatic test_reset_mid_init();
    int cyc;
    drive(1'b0, 1'b1, 4'd9, 8'h77);
    n_tests++;
    if (bus.gnt0 !== 1'b1) begin n_fail++; $display("FAIL mid_wr_gnt: got %b required 1", bus.gnt0); end
    do_reset();
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b required 1", bus.busy); end
    @(negedge clk);
    rst = 1'b0;
    wait_init(cyc);
    n_tests++;
    if (cyc !== 16) begin n_fail++; $display("FAIL mid_init_len: got %0d required 16", cyc); end
    drive(1'b1, 1'b0, 4'd9, 8'h00);
    n_tests++;
    if (bus.gnt1 !== 1'b1) begin n_fail++; $display("FAIL mid_rd_gnt: got %b required 1", bus.gnt1); end
    idle_cycle();
    n_tests++;
    if ({bus.rvalid1, bus.rdata} !== {1'b1, 8'h00}) begin
      n_fail++; $display("FAIL mid_rd: got rv1=%b rdata=%h required rv1=1 rdata=00", bus.rvalid1, bus.rdata);
    end
  endtask

  task automatic test_reset_drops_rvalid();
    int cyc;
    drive(1'b1, 1'b1, 4'd2, 8'h5A);
    n_tests++;
    if (bus.gnt1 !== 1'b1) begin n_fail++; $display("FAIL drop_wr_gnt: got %b required 1", bus.gnt1); end
    drive(1'b1, 1'b0, 4'd2, 8'h00);
    n_tests++;
    if (bus.gnt1 !== 1'b1) begin n_fail++; $display("FAIL drop_rd_gnt: got %b required 1", bus.gnt1); end
    @(negedge clk);
    clear_reqs();
    rst = 1'b1;
    #1;
    n_tests++;
    if ({bus.rvalid0, bus.rvalid1, bus.rdata} !== {2'b00, 8'h00}) begin
      n_fail++; $display("FAIL drop_rv: got rv=%b%b rdata=%h required rv=00 rdata=00", bus.rvalid0, bus.rvalid1, bus.rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_init(cyc);
    n_tests++;
    if ({bus.rvalid1, bus.busy, bus.rdata} !== {2'b00, 8'h00}) begin
      n_fail++; $display("FAIL drop_after: got rv1=%b busy=%b rdata=%h required 0 0 00", bus.rvalid1, bus.busy, bus.rdata);
    end
  endtask

  task automatic test_match();
    logic [7:0] vals [3];
    logic       exp_m;
    vals[0] = 8'h05; vals[1] = 8'h06; vals[2] = 8'h0A;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 4'(4 + i), vals[i]);
      n_tests++;
      if (bus.gnt0 !== 1'b1) begin n_fail++; $display("FAIL match_wr_gnt: addr %0d got %b required 1", 4 + i, bus.gnt0); end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 4'(4 + i), 8'h00);
      idle_cycle();
`ifdef MEM_ARB_MATCH_EN
      exp_m = (i != 1);
`else
      exp_m = 1'b0;
`endif
      n_tests++;
      if ({bus.rvalid0, bus.rdata, bus.rmatch} !== {1'b1, vals[i], exp_m}) begin
        n_fail++; $display("FAIL match_rd: addr %0d got rv0=%b rdata=%h rmatch=%b required rv0=1 rdata=%h rmatch=%b",
                           4 + i, bus.rvalid0, bus.rdata, bus.rmatch, vals[i], exp_m);
      end
    end
  endtask

  initial begin
    test_reset();
    test_init_reads();
    test_write_read();
    test_contention();
    test_reset_mid_init();
    test_reset_drops_rvalid();
    test_match();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_share_arbiter.md
# mem_share_arbiter

Two-requester controller for a shared 16 x 8-bit register array. After reset it sequences an initialisation pass that clears every entry, then arbitrates single-cycle read and write accesses from two requesters using round-robin priority and returns read data one cycle later. It sits between two client blocks and the storage they share, and owns the array outright.

## Interface
- DW, 8, data width of each entry
- AW, 4, address width
- DEPTH, 16, number of entries (2**AW)

Reset is rst, asynchronous, active-high; the clock is clk.

- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req0, req1  in  1  access request from requester 0 / 1; held until granted
- we0, we1  in  1  1 = write, 0 = read; valid while reqN is high
- addr0, addr1  in  AW  access address
- wdata0, wdata1  in  DW  write data
- gnt0, gnt1  out  1  combinational grant; the access is performed at the clock edge that ends the grant cycle
- rvalid0, rvalid1  out  1  one-cycle pulse: rdata holds the requester's read result
- rdata  out  DW  registered read data, shared by both requesters
- rmatch  out  1  rdata is a member of the match set (see Configuration); meaningful only while an rvalid is high
- busy  out  1  initialisation pass in progress; no grants are issued

## Operation
- FSM states are INIT and RUN. Reset forces INIT, sets the clear pointer clr_ptr to 0, and sets last_gnt to 1.
- INIT: each cycle writes 0 to mem[clr_ptr] and increments clr_ptr. When clr_ptr == DEPTH-1 is written, the FSM moves to RUN on the next edge. INIT therefore lasts exactly DEPTH cycles. busy = 1 and gnt0 = gnt1 = 0 throughout INIT.
- RUN, arbitration:
  - Only req0: gnt0 = 1.
  - Only req1: gnt1 = 1.
  - Both: grant goes to the requester that was not last granted.
  - At most one grant per cycle. last_gnt updates only on a grant.
- Granted write: mem[addr] <= wdata at that edge.
- Granted read: rdata <= mem[addr] at that edge. The matching rvalidN pulses high for the following cycle.
- rdata holds its value until the next granted read.
- A read granted in the cycle after a write to the same address returns the new data.
- The array has no reset; its contents are defined only by INIT.
- Reset mid-INIT or mid-RUN restarts INIT. Any read response not yet delivered is dropped: rvalid is forced to 0.

## Timing
- Reset values: gnt0/1 = 0, rvalid0/1 = 0, rdata = 0, rmatch = 0, busy = 1.
- Latency:
  - Grant is combinational from req in RUN.
  - Write takes effect at the grant edge.
  - Read: rvalid and rdata are valid exactly 1 cycle after the grant cycle.
- Throughput: one access per cycle. Under continuous contention from both requesters, each one is granted every other cycle.
- First grant possible in the cycle after INIT completes, i.e. DEPTH+1 cycles after reset deassertion.
- Requester rule: req, we, addr and wdata are held stable until the grant cycle. Dropping req before the grant withdraws the request.

## Configuration
- MEM_ARB_MATCH_EN defined: rmatch is registered alongside rdata. It is 1 when the value read is 8'd0, 8'd5 or 8'd10, and 0 otherwise. This is a set-membership check on the read result.
- MEM_ARB_MATCH_EN undefined: rmatch is tied to 0 and no compare logic is built.

## Test plan
- Reset then idle:
  - busy = 1 for 16 cycles, then 0.
  - No gnt during INIT.
  - Reads of addresses 0..15 all return 0x00 with rvalid one cycle after the grant.
- Requester 0 writes 0xA5 to address 3, then reads address 3 in the next cycle: rdata = 0xA5 with rvalid0 pulsing for one cycle, and rvalid1 stays 0.
- Both requesters request continuously, requester 0 reading address 1 and requester 1 reading address 2:
  - Grants alternate gnt0, gnt1, gnt0, ..., starting with gnt0.
  - rvalid alternates in the same order, delayed by one cycle.
- Reset asserted at cycle 7 of INIT:
  - busy stays 1.
  - INIT restarts and runs a full 16 cycles after release.
  - A location written before the reset reads back 0x00.
- Requester 1 issues a read whose rvalid would pulse in the next cycle, and rst is asserted in that cycle: no rvalid pulse appears, and rdata = 0.
- With MEM_ARB_MATCH_EN, write 0x05, 0x06 and 0x0A to addresses 4, 5 and 6, then read them: rmatch = 1, 0, 1. Without the macro, rmatch stays 0 throughout.
